lsu_load_wb: RTL and testbench
==============================

# lsu_load_wb

Load-writeback unit for the single-cycle-with-SRAM core: accepts one load at a time from the execute stage, issues a word read to data SRAM, waits for the response, extracts/sign-extends the byte/half/word and drives the register-file write port. Also muxes the ALU writeback onto the same port and flags read-after-load hazards on rs1/rs2 so the pipeline control can stall.

## Interface
- TIMEOUT_CYCLES, 64: WAIT-state watchdog limit, only used when LSU_TIMEOUT_EN is defined.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_ld_valid  in  1  load request valid.
- o_ld_ready  out  1  unit can accept a load (high only in IDLE).
- i_ld_addr  in  32  byte address.
- i_ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal.
- i_ld_rd  in  5  destination register.
- o_sram_req  out  1  one-cycle read strobe.
- o_sram_addr  out  32  word address ({addr[31:2],2'b00}).
- i_sram_rvalid  in  1  read data valid.
- i_sram_rdata  in  32  read word.
- i_alu_wren / i_alu_rd / i_alu_data  in  1/5/32  ALU writeback request.
- o_alu_stall  out  1  ALU writeback blocked this cycle.
- i_rs1_addr, i_rs2_addr  in  5  decode-stage source registers.
- o_hazard  out  1  rs1 or rs2 matches pending load rd.
- o_rd_wren / o_rd_addr / o_rd_data  out  1/5/32  register-file write port.
- o_ld_misalign  out  1  one-cycle pulse, load rejected.
- o_ld_timeout  out  1  one-cycle pulse (LSU_TIMEOUT_EN only; tied 0 otherwise).

## Operation
- FSM states IDLE, WAIT, WRITE. Reset: IDLE, all registered outputs 0, latched rd/offset/funct3/result 0.
- IDLE: o_ld_ready=1. On i_ld_valid: if misaligned (LH/LHU addr[0]=1, LW addr[1:0]!=0) or illegal funct3 -> pulse o_ld_misalign next cycle, stay IDLE, no SRAM access. Else latch rd, addr[1:0], funct3, o_sram_addr; go WAIT.
- WAIT: o_sram_req=1 in first WAIT cycle only. On i_sram_rvalid: align/extend rdata into result reg, go WRITE. rvalid outside WAIT ignored.
- WRITE: o_rd_wren=1 iff latched rd!=0, o_rd_addr=rd, o_rd_data=result; go IDLE.
- Extraction: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
- ALU path: outside WRITE, o_rd_* = i_alu_* combinationally (o_rd_wren=i_alu_wren && i_alu_rd!=0). In WRITE, load wins, o_alu_stall=i_alu_wren.
- o_hazard (combinational) = state!=IDLE && rd!=0 && (rd==i_rs1_addr || rd==i_rs2_addr).
- Reset asserted mid-load: immediate IDLE, pending write discarded, no o_rd_wren.

## Timing
- Load accepted at edge N -> o_sram_req cycle N+1 -> rvalid earliest N+1 -> o_rd_wren cycle N+2 -> o_ld_ready high N+3.
- rvalid arriving k cycles after req adds k cycles; no back-to-back loads (one outstanding).
- o_ld_misalign asserted exactly one cycle, cycle N+1.

## Configuration
- LSU_TIMEOUT_EN defined: counter cleared on WAIT entry, increments each WAIT cycle without rvalid; reaching TIMEOUT_CYCLES -> pulse o_ld_timeout, go IDLE, no write, hazard released.
- Not defined: no counter, WAIT holds indefinitely, o_ld_timeout constant 0.

## Structure
- lsu_pkg: funct3 localparams (F3_LB..F3_LHU), state enum typedef lsu_state_e, misalignment function.
- Sub-module load_align: combinational (rdata, offset, funct3) -> 32-bit extended result.

## Test plan
- LB addr 0x103, rd=5, rdata 0x80AABBCC next cycle -> o_rd_data 0xFFFFFF80, rd 5, write cycle N+2.
- LHU addr 0x102, rdata 0x8001_1234 -> 0x00008001; LW addr 0x100 rd=0 -> no o_rd_wren.
- LW addr 0x101 -> o_ld_misalign one cycle, o_sram_req never asserted, o_ld_ready stays 1.
- Pending LW rd=7, i_rs2_addr=7 -> o_hazard=1 until WRITE completes; ALU write rd=3 during WRITE -> o_alu_stall=1, load data written.
- rvalid delayed 5 cycles; i_rst pulsed mid-WAIT -> outputs 0, later rvalid ignored, no write.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no rvalid -> o_ld_timeout pulse after 4 WAIT cycles, return IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load funct3 codes, FSM state type and load legality check
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } lsu_state_e;

  // True when the load must be rejected: illegal funct3 or unaligned access.
  function automatic logic ld_reject(input logic [2:0] funct3, input logic [1:0] off);
    logic bad;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = off[0];
      F3_LW:         bad = (off != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a read word and extends it to 32 bits
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{off_i, 3'b000} +: 8];
  assign half_v = rdata_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    result_o = '0;
    case (funct3_i)
      F3_LB:   result_o = {{24{byte_v[7]}}, byte_v};
      F3_LH:   result_o = {{16{half_v[15]}}, half_v};
      F3_LW:   result_o = rdata_i;
      F3_LBU:  result_o = {24'h0, byte_v};
      F3_LHU:  result_o = {16'h0, half_v};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_load_wb.sv
// rtl/lsu_load_wb.sv - single-outstanding load unit with ALU writeback mux; LSU_TIMEOUT_EN adds a WAIT watchdog
module lsu_load_wb
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [31:0] i_ld_addr,
  input  logic [2:0]  i_ld_funct3,
  input  logic [4:0]  i_ld_rd,
  output logic        o_sram_req,
  output logic [31:0] o_sram_addr,
  input  logic        i_sram_rvalid,
  input  logic [31:0] i_sram_rdata,
  input  logic        i_alu_wren,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_stall,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_hazard,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_ld_misalign,
  output logic        o_ld_timeout
);

  lsu_state_e  state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] result_q, result_d;
  logic        req_q, req_d;
  logic        misalign_q, misalign_d;
  logic [31:0] align_result;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  load_align u_align (
    .rdata_i  (i_sram_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .result_o (align_result)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rd_q       <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      addr_q     <= '0;
      result_q   <= '0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      result_q   <= result_d;
      req_q      <= req_d;
      misalign_q <= misalign_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    off_d      = off_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    result_d   = result_q;
    req_d      = 1'b0;
    misalign_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_ld_valid) begin
          if (ld_reject(i_ld_funct3, i_ld_addr[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            rd_d    = i_ld_rd;
            off_d   = i_ld_addr[1:0];
            f3_d    = i_ld_funct3;
            addr_d  = {i_ld_addr[31:2], 2'b00};
            req_d   = 1'b1;
            state_d = ST_WAIT;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_WAIT: begin
        if (i_sram_rvalid) begin
          result_d = align_result;
          state_d  = ST_WRITE;
        end else begin
`ifdef LSU_TIMEOUT_EN
          // Abandon the load once TIMEOUT_CYCLES WAIT cycles have passed without data.
          if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign o_ld_ready    = (state_q == ST_IDLE);
  assign o_sram_req    = req_q;
  assign o_sram_addr   = addr_q;
  assign o_ld_misalign = misalign_q;
`ifdef LSU_TIMEOUT_EN
  assign o_ld_timeout  = timeout_q;
`else
  assign o_ld_timeout  = 1'b0;
`endif

  // Load writeback owns the register-file port during WRITE; ALU is stalled.
  always_comb begin
    o_alu_stall = 1'b0;
    if (state_q == ST_WRITE) begin
      o_rd_wren   = (rd_q != 5'd0);
      o_rd_addr   = rd_q;
      o_rd_data   = result_q;
      o_alu_stall = i_alu_wren;
    end else begin
      o_rd_wren = i_alu_wren && (i_alu_rd != 5'd0);
      o_rd_addr = i_alu_rd;
      o_rd_data = i_alu_data;
    end
  end

  assign o_hazard = (state_q != ST_IDLE) && (rd_q != 5'd0) &&
                    ((rd_q == i_rs1_addr) || (rd_q == i_rs2_addr));

endmodule

// File: tb/tb_lsu_load_wb.sv
// tb/tb_lsu_load_wb.sv - directed self-checking bench for lsu_load_wb
module tb_lsu_load_wb;
  import lsu_pkg::*;

`ifdef LSU_TIMEOUT_EN
  localparam int DELAY = 3;
`else
  localparam int DELAY = 5;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ld_valid;
  logic        o_ld_ready;
  logic [31:0] i_ld_addr;
  logic [2:0]  i_ld_funct3;
  logic [4:0]  i_ld_rd;
  logic        o_sram_req;
  logic [31:0] o_sram_addr;
  logic        i_sram_rvalid;
  logic [31:0] i_sram_rdata;
  logic        i_alu_wren;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_stall;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        o_hazard;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_ld_misalign;
  logic        o_ld_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_load_wb #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ld_valid    (i_ld_valid),
    .o_ld_ready    (o_ld_ready),
    .i_ld_addr     (i_ld_addr),
    .i_ld_funct3   (i_ld_funct3),
    .i_ld_rd       (i_ld_rd),
    .o_sram_req    (o_sram_req),
    .o_sram_addr   (o_sram_addr),
    .i_sram_rvalid (i_sram_rvalid),
    .i_sram_rdata  (i_sram_rdata),
    .i_alu_wren    (i_alu_wren),
    .i_alu_rd      (i_alu_rd),
    .i_alu_data    (i_alu_data),
    .o_alu_stall   (o_alu_stall),
    .i_rs1_addr    (i_rs1_addr),
    .i_rs2_addr    (i_rs2_addr),
    .o_hazard      (o_hazard),
    .o_rd_wren     (o_rd_wren),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_ld_misalign (o_ld_misalign),
    .o_ld_timeout  (o_ld_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic drive_ld(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
    i_ld_valid  = 1'b1;
    i_ld_addr   = addr;
    i_ld_funct3 = f3;
    i_ld_rd     = rd;
  endtask

  task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                          input logic [31:0] exp_data);
    next_cycle();
    drive_ld(addr, f3, rd);
    sample();
    expect_eq({tag, "_ready_idle"}, 32'(o_ld_ready), 32'd1);
    next_cycle();
    i_ld_valid = 1'b0;
    for (int d = 0; d < delay; d++) begin
      sample();
      expect_eq({tag, "_req_wait"}, 32'(o_sram_req), 32'(d == 0));
      expect_eq({tag, "_ready_wait"}, 32'(o_ld_ready), 32'd0);
      expect_eq({tag, "_timeout_wait"}, 32'(o_ld_timeout), 32'd0);
      next_cycle();
    end
    i_sram_rvalid = 1'b1;
    i_sram_rdata  = rdata;
    sample();
    expect_eq({tag, "_req"}, 32'(o_sram_req), 32'(delay == 0));
    expect_eq({tag, "_sram_addr"}, o_sram_addr, {addr[31:2], 2'b00});
    expect_eq({tag, "_wren_early"}, 32'(o_rd_wren), 32'd0);
    next_cycle();
    i_sram_rvalid = 1'b0;
    sample();
    expect_eq({tag, "_wren"}, 32'(o_rd_wren), 32'(rd != 5'd0));
    expect_eq({tag, "_rd_addr"}, 32'(o_rd_addr), 32'(rd));
    expect_eq({tag, "_rd_data"}, o_rd_data, exp_data);
    next_cycle();
    sample();
    expect_eq({tag, "_ready_after"}, 32'(o_ld_ready), 32'd1);
    expect_eq({tag, "_wren_after"}, 32'(o_rd_wren), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1;
    i_ld_valid = 1'b0; i_ld_addr = '0; i_ld_funct3 = '0; i_ld_rd = '0;
    i_sram_rvalid = 1'b0; i_sram_rdata = '0;
    i_alu_wren = 1'b0; i_alu_rd = '0; i_alu_data = '0;
    i_rs1_addr = '0; i_rs2_addr = '0;

    repeat (2) @(posedge i_clk);
    sample();
    expect_eq("rst_ready", 32'(o_ld_ready), 32'd1);
    expect_eq("rst_req", 32'(o_sram_req), 32'd0);
    expect_eq("rst_sram_addr", o_sram_addr, 32'd0);
    expect_eq("rst_wren", 32'(o_rd_wren), 32'd0);
    expect_eq("rst_misalign", 32'(o_ld_misalign), 32'd0);
    expect_eq("rst_timeout", 32'(o_ld_timeout), 32'd0);
    expect_eq("rst_hazard", 32'(o_hazard), 32'd0);
    next_cycle();
    i_rst = 1'b0;

    run_load("lb",  32'h0000_0103, F3_LB,  5'd5, 32'h80AA_BBCC, 0, 32'hFFFF_FF80);
    run_load("lhu", 32'h0000_0102, F3_LHU, 5'd9, 32'h8001_1234, 0, 32'h0000_8001);
    run_load("lw0", 32'h0000_0100, F3_LW,  5'd0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    run_load("lbu", 32'h0000_0101, F3_LBU, 5'd2, 32'h1234_F0AB, 0, 32'h0000_00F0);
    run_load("lh_dly", 32'h0000_0402, F3_LH, 5'd6, 32'h8001_7FFF, DELAY, 32'hFFFF_8001);

    // Misaligned LW then illegal funct3: single-cycle pulse, no SRAM access.
    next_cycle();
    drive_ld(32'h0000_0101, F3_LW, 5'd3);
    sample();
    next_cycle();
    i_ld_valid = 1'b0;
    sample();
    expect_eq("mis_pulse", 32'(o_ld_misalign), 32'd1);
    expect_eq("mis_ready", 32'(o_ld_ready), 32'd1);
    expect_eq("mis_req", 32'(o_sram_req), 32'd0);
    next_cycle();
    sample();
    expect_eq("mis_pulse_end", 32'(o_ld_misalign), 32'd0);
    expect_eq("mis_req2", 32'(o_sram_req), 32'd0);
    expect_eq("mis_ready2", 32'(o_ld_ready), 32'd1);
    next_cycle();
    drive_ld(32'h0000_0200, 3'b011, 5'd3);
    sample();
    next_cycle();
    i_ld_valid = 1'b0;
    sample();
    expect_eq("ill_pulse", 32'(o_ld_misalign), 32'd1);
    expect_eq("ill_req", 32'(o_sram_req), 32'd0);

    // Hazard on rs2 while LW rd=7 is pending; ALU write stalled during WRITE.
    i_rs1_addr = 5'd1;
    i_rs2_addr = 5'd7;
    next_cycle();
    drive_ld(32'h0000_0200, F3_LW, 5'd7);
    sample();
    expect_eq("haz_idle", 32'(o_hazard), 32'd0);
    next_cycle();
    i_ld_valid = 1'b0;
    sample();
    expect_eq("haz_wait1", 32'(o_hazard), 32'd1);
    next_cycle();
    i_sram_rvalid = 1'b1;
    i_sram_rdata  = 32'h1122_3344;
    sample();
    expect_eq("haz_wait2", 32'(o_hazard), 32'd1);
    next_cycle();
    i_sram_rvalid = 1'b0;
    i_alu_wren = 1'b1; i_alu_rd = 5'd3; i_alu_data = 32'h0000_AAAA;
    sample();
    expect_eq("haz_write", 32'(o_hazard), 32'd1);
    expect_eq("stall_write", 32'(o_alu_stall), 32'd1);
    expect_eq("stall_wren", 32'(o_rd_wren), 32'd1);
    expect_eq("stall_rd_addr", 32'(o_rd_addr), 32'd7);
    expect_eq("stall_rd_data", o_rd_data, 32'h1122_3344);
    next_cycle();
    sample();
    expect_eq("haz_release", 32'(o_hazard), 32'd0);
    expect_eq("alu_stall_idle", 32'(o_alu_stall), 32'd0);
    expect_eq("alu_wren", 32'(o_rd_wren), 32'd1);
    expect_eq("alu_rd_addr", 32'(o_rd_addr), 32'd3);
    expect_eq("alu_rd_data", o_rd_data, 32'h0000_AAAA);
    next_cycle();
    i_alu_rd = 5'd0;
    sample();
    expect_eq("alu_x0_wren", 32'(o_rd_wren), 32'd0);
    i_alu_wren = 1'b0;

    // Reset in the middle of WAIT: write discarded, late rvalid ignored.
    i_rs1_addr = 5'd4;
    next_cycle();
    drive_ld(32'h0000_0300, F3_LB, 5'd4);
    sample();
    next_cycle();
    i_ld_valid = 1'b0;
    sample();
    expect_eq("rstw_req", 32'(o_sram_req), 32'd1);
    expect_eq("rstw_hazard", 32'(o_hazard), 32'd1);
    next_cycle();
    sample();
    expect_eq("rstw_req_once", 32'(o_sram_req), 32'd0);
    next_cycle();
    i_rst = 1'b1;
    #1;
    expect_eq("rstw_ready", 32'(o_ld_ready), 32'd1);
    expect_eq("rstw_hazard_clr", 32'(o_hazard), 32'd0);
    expect_eq("rstw_sram_addr", o_sram_addr, 32'd0);
    next_cycle();
    i_rst = 1'b0;
    i_sram_rvalid = 1'b1;
    i_sram_rdata  = 32'hFFFF_FFFF;
    sample();
    expect_eq("rstw_late_wren", 32'(o_rd_wren), 32'd0);
    next_cycle();
    i_sram_rvalid = 1'b0;
    sample();
    expect_eq("rstw_late_wren2", 32'(o_rd_wren), 32'd0);
    expect_eq("rstw_late_ready", 32'(o_ld_ready), 32'd1);

`ifdef LSU_TIMEOUT_EN
    i_rs1_addr = 5'd8;
    next_cycle();
    drive_ld(32'h0000_0500, F3_LW, 5'd8);
    sample();
    next_cycle();
    i_ld_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      expect_eq("tmo_quiet", 32'(o_ld_timeout), 32'd0);
      expect_eq("tmo_hazard", 32'(o_hazard), 32'd1);
      next_cycle();
    end
    sample();
    expect_eq("tmo_pulse", 32'(o_ld_timeout), 32'd1);
    expect_eq("tmo_ready", 32'(o_ld_ready), 32'd1);
    expect_eq("tmo_hazard_clr", 32'(o_hazard), 32'd0);
    expect_eq("tmo_wren", 32'(o_rd_wren), 32'd0);
    next_cycle();
    sample();
    expect_eq("tmo_pulse_end", 32'(o_ld_timeout), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
